// File: rtl/mult_req_pkg.sv
// Shared types and defaults for the multiplier request initiator.
package mult_req_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      REQ   = 3'd2,
      WAIT  = 3'd3,
      OUT   = 3'd4
   } mult_req_state_t;

   localparam int TIMEOUT_DFLT = 64;
   localparam int CNT_W_DFLT   = 16;

   function automatic int prod_w(input int width);
      return 2 * width;
   endfunction

endpackage

// File: rtl/mult_req_timer.sv
// WAIT-phase cycle counter: clear has priority over enable; exp_o flags the last allowed cycle.
module mult_req_timer #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic exp_o
);
   localparam int TW = $clog2(TIMEOUT);

   logic [TW-1:0] cnt_q;
   logic [TW-1:0] cnt_d;

   // counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // next count
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + TW'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   assign exp_o = (cnt_q == TW'(TIMEOUT - 1));

endmodule

// File: rtl/mult_requester.sv
// Initiator side of the multiplier req/rdy/done handshake with valid/ready operand and result streams.
module mult_requester
   import mult_req_pkg::*;
#(
   parameter int WIDTH   = 5,
   parameter int TIMEOUT = TIMEOUT_DFLT,
   parameter int CNT_W   = CNT_W_DFLT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   output logic                 req,
   input  logic                 rdy,
   output logic [WIDTH-1:0]     a,
   output logic [WIDTH-1:0]     b,
   input  logic                 done,
   input  logic [2*WIDTH-1:0]   ab,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out_ab,
   output logic                 out_err,
   output logic [CNT_W-1:0]     txn_cnt
);
   localparam int PW = prod_w(WIDTH);

   mult_req_state_t  state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [PW-1:0]    out_ab_q, out_ab_d;
   logic             out_err_q, out_err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             req_q, out_valid_q;
   logic             tmr_clr_s, tmr_en_s, tmr_exp_s;

   mult_req_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (tmr_clr_s),
      .en_i  (tmr_en_s),
      .exp_o (tmr_exp_s)
   );

   // state and datapath registers; req/out_valid are decoded from the next state so they stay registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         out_ab_q    <= '0;
         out_err_q   <= 1'b0;
         cnt_q       <= '0;
         req_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         out_ab_q    <= out_ab_d;
         out_err_q   <= out_err_d;
         cnt_q       <= cnt_d;
         req_q       <= (state_d == REQ);
         out_valid_q <= (state_d == OUT);
      end
   end

   // next-state and datapath update
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      out_ab_d  = out_ab_q;
      out_err_d = out_err_q;
      cnt_d     = cnt_q;
      tmr_clr_s = 1'b0;
      tmr_en_s  = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = in_a;
               b_d     = in_b;
               state_d = ISSUE;
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE: begin
            if (rdy) begin
               state_d = REQ;
            end else begin
               state_d = ISSUE;
            end
         end
         REQ: begin
            tmr_clr_s = 1'b1;
            state_d   = WAIT;
         end
         WAIT: begin
            tmr_en_s = 1'b1;
            // done beats a simultaneous expiry
            if (done) begin
               out_ab_d  = ab;
               out_err_d = 1'b0;
               state_d   = OUT;
            end else if (tmr_exp_s) begin
               out_ab_d  = '0;
               out_err_d = 1'b1;
               state_d   = OUT;
            end else begin
               state_d = WAIT;
            end
         end
         OUT: begin
            if (out_ready) begin
               state_d = IDLE;
               if (!out_err_q) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end else begin
                  cnt_d = cnt_q;
               end
            end else begin
               state_d = OUT;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign req       = req_q;
   assign a         = a_q;
   assign b         = b_q;
   assign out_valid = out_valid_q;
   assign out_ab    = out_ab_q;
   assign out_err   = out_err_q;
   assign txn_cnt   = cnt_q;

endmodule

// File: tb/tb_mult_requester.sv
// Self-checking bench: directed vector table, corner sequences and random transactions vs. a timing formula model.
module tb_mult_requester;
   localparam int W  = 5;
   localparam int TO = 64;
   localparam int CW = 3;

   logic              clk = 1'b0, rst_n = 1'b0;
   logic              in_valid = 1'b0, in_ready, req, rdy = 1'b0, done = 1'b0;
   logic              out_valid, out_ready = 1'b0, out_err;
   logic [W-1:0]      in_a = '0, in_b = '0, a, b;
   logic [2*W-1:0]    ab = '0, out_ab;
   logic [CW-1:0]     txn_cnt;

   int checks = 0, failures = 0, cyc = 0, cd = 0, mlat = 5, exp_cnt = 0;
   bit mnever = 1'b0;
   logic [2*W-1:0] last_ab = '0;

   typedef struct {
      logic [W-1:0]   ia, ib;
      int             lat;
      bit             never;
      int             rs, os;
      logic [2*W-1:0] exp_ab;
      logic           exp_err;
      int             exp_tval;
   } vec_t;
   vec_t vecs[8];

   always #5 clk = ~clk;

   mult_requester #(.WIDTH(W), .TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .req(req), .rdy(rdy), .a(a), .b(b),
      .done(done), .ab(ab), .out_valid(out_valid), .out_ready(out_ready),
      .out_ab(out_ab), .out_err(out_err), .txn_cnt(txn_cnt)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   // one clock step; the multiplier model answers mlat cycles after it sees req
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      done = 1'b0;
      if (cd > 0) begin
         cd--;
         if (cd == 0) begin
            done = 1'b1;
            ab   = {5'd0, a} * {5'd0, b};
         end
      end
      if (req === 1'b1 && !mnever) cd = mlat;
   endtask

   task automatic run_txn(input logic [W-1:0] ia, input logic [W-1:0] ib, input int lat,
                          input bit never, input int rs, input int os,
                          output logic [2*W-1:0] g_ab, output logic g_err,
                          output int t_req, output int t_val, output int rw,
                          output bit stable, output bit finished);
      int base, rel, ovc;
      bit hs;
      mlat = lat; mnever = never; cd = 0;
      t_req = -1; t_val = -1; rw = 0; stable = 1'b1; ovc = 0; hs = 1'b0; finished = 1'b0;
      g_ab = '0; g_err = 1'b0;
      in_a = ia; in_b = ib; in_valid = 1'b1; rdy = (rs == 0); out_ready = 1'b0;
      base = cyc;
      for (int n = 0; n < 300; n++) begin
         tick();
         if (hs) begin
            in_valid = 1'b0; out_ready = 1'b0; finished = 1'b1;
            break;
         end
         rel  = cyc - base;
         in_a = W'($urandom);
         in_b = W'($urandom);
         rdy  = (rel > rs);
         if (a !== ia || b !== ib || in_ready !== 1'b0) stable = 1'b0;
         if (req === 1'b1) begin
            rw++;
            if (t_req < 0) t_req = rel;
         end
         if (out_valid === 1'b1) begin
            ovc++;
            if (ovc == 1) begin
               t_val = rel; g_ab = out_ab; g_err = out_err;
            end else if (out_ab !== g_ab || out_err !== g_err) begin
               stable = 1'b0;
            end
            out_ready = (ovc > os);
            hs = out_ready;
         end else begin
            out_ready = 1'($urandom_range(0, 1));
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic check_txn(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                            input int lat, input bit never, input int rs, input int os,
                            input logic [2*W-1:0] exp_ab, input logic exp_err, input int exp_tval);
      logic [2*W-1:0] g_ab;
      logic g_err;
      int t_req, t_val, rw;
      bit stable, finished;
      run_txn(ia, ib, lat, never, rs, os, g_ab, g_err, t_req, t_val, rw, stable, finished);
      chk({tag, ".completed"}, 32'(finished), 32'd1);
      chk({tag, ".out_ab"}, 32'(g_ab), 32'(exp_ab));
      chk({tag, ".out_err"}, 32'(g_err), 32'(exp_err));
      chk({tag, ".t_req"}, t_req, 2 + rs);
      chk({tag, ".req_width"}, rw, 1);
      chk({tag, ".t_valid"}, t_val, exp_tval);
      chk({tag, ".stable"}, 32'(stable), 32'd1);
      chk({tag, ".idle_after"}, {30'd0, in_ready, out_valid}, 32'd2);
      if (!exp_err) exp_cnt++;
      chk({tag, ".txn_cnt"}, 32'(txn_cnt), 32'(exp_cnt % (1 << CW)));
      last_ab = exp_ab;
   endtask

   task automatic mid_reset(input string tag);
      #2;
      rst_n = 1'b0;
      #1;
      chk({tag, ".req"}, 32'(req), 32'd0);
      chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, ".txn_cnt"}, 32'(txn_cnt), 32'd0);
      chk({tag, ".a"}, 32'(a), 32'd0);
      chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
      #1;
      rst_n = 1'b1;
      cd = 0;
      exp_cnt = 0;
      last_ab = '0;
   endtask

   initial begin
      logic [W-1:0]   ia, ib;
      int             lat, rs, os, tval;
      bit             never, err;
      logic [2*W-1:0] eab;

      vecs[0] = '{5'd31, 5'd31, 5,  1'b0, 0,  0, 10'd961, 1'b0, 8};
      vecs[1] = '{5'd3,  5'd7,  5,  1'b0, 0,  7, 10'd21,  1'b0, 8};
      vecs[2] = '{5'd5,  5'd6,  5,  1'b0, 10, 0, 10'd30,  1'b0, 18};
      vecs[3] = '{5'd9,  5'd9,  5,  1'b1, 0,  0, 10'd0,   1'b1, 67};
      vecs[4] = '{5'd7,  5'd11, 64, 1'b0, 0,  0, 10'd77,  1'b0, 67};
      vecs[5] = '{5'd4,  5'd4,  65, 1'b0, 0,  0, 10'd0,   1'b1, 67};
      vecs[6] = '{5'd0,  5'd31, 1,  1'b0, 0,  2, 10'd0,   1'b0, 4};
      vecs[7] = '{5'd31, 5'd1,  1,  1'b0, 3,  1, 10'd31,  1'b0, 7};

      #2;
      chk("rst.in_ready", 32'(in_ready), 32'd1);
      chk("rst.req", 32'(req), 32'd0);
      chk("rst.out_valid", 32'(out_valid), 32'd0);
      chk("rst.out_ab", 32'(out_ab), 32'd0);
      chk("rst.out_err", 32'(out_err), 32'd0);
      chk("rst.txn_cnt", 32'(txn_cnt), 32'd0);
      chk("rst.ab_regs", {22'd0, a, b}, 32'd0);
      #10;
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 8; i++) begin
         check_txn($sformatf("vec%0d", i), vecs[i].ia, vecs[i].ib, vecs[i].lat, vecs[i].never,
                   vecs[i].rs, vecs[i].os, vecs[i].exp_ab, vecs[i].exp_err, vecs[i].exp_tval);
      end

      done = 1'b1;
      ab   = 10'd777;
      tick();
      chk("stray.in_ready", 32'(in_ready), 32'd1);
      chk("stray.out_valid", 32'(out_valid), 32'd0);
      chk("stray.out_ab", 32'(out_ab), 32'(last_ab));
      tick();
      chk("stray.still_idle", 32'(in_ready), 32'd1);

      for (int i = 0; i < 24; i++) begin
         ia = W'($urandom);
         ib = W'($urandom);
         rs = $urandom_range(0, 3);
         os = $urandom_range(0, 3);
         never = 1'b0;
         case ($urandom_range(0, 9))
            0:       begin never = 1'b1; lat = 5; end
            1:       lat = $urandom_range(62, 66);
            default: lat = $urandom_range(1, 8);
         endcase
         err  = never || (lat > TO);
         eab  = err ? 10'd0 : ({5'd0, ia} * {5'd0, ib});
         tval = 2 + rs + 1 + (err ? TO : lat);
         check_txn($sformatf("rnd%0d", i), ia, ib, lat, never, rs, os, eab, err, tval);
      end

      mnever = 1'b1; cd = 0;
      in_a = 5'd13; in_b = 5'd3; in_valid = 1'b1; rdy = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      chk("rst_req.req_high", 32'(req), 32'd1);
      mid_reset("rst_req");

      in_a = 5'd13; in_b = 5'd3; in_valid = 1'b1; rdy = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      mid_reset("rst_wait");
      chk("rst_wait.out_ab", 32'(out_ab), 32'd0);

      check_txn("post_rst", 5'd2, 5'd2, 5, 1'b0, 0, 0, 10'd4, 1'b0, 8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
